// File: rtl/add_acc_pkg.sv
// Shared definitions for the add-accumulate unit: FSM state encoding and the
// reference arithmetic for one accumulate step (wrap or saturate). The same
// functions serve the RTL datapath and any bench-side reference model.
// Operands are passed zero-extended to MAX_W bits so one function covers
// every WIDTH up to MAX_W.
package add_acc_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } acc_state_t;

   // Widest operand the shared arithmetic supports.
   localparam int unsigned MAX_W = 64;
   // Two guard bits: acc + a + b never exceeds 3*(2^W-1) < 2^(W+2).
   localparam int unsigned EXT_W = MAX_W + 2;

   // All-ones value of a WIDTH-bit result, carried at EXT_W bits.
   function automatic logic [EXT_W-1:0] acc_limit(input int width);
      return (EXT_W'(1) << width) - EXT_W'(1);
   endfunction

   // Exact sum of one step, wide enough that it can never wrap.
   function automatic logic [EXT_W-1:0] acc_raw(
      input logic [MAX_W-1:0] acc,
      input logic [MAX_W-1:0] a,
      input logic [MAX_W-1:0] b
   );
      return EXT_W'(acc) + EXT_W'(a) + EXT_W'(b);
   endfunction

   // True when the exact sum no longer fits in WIDTH bits. Because acc is
   // always <= limit, this equals "next[WIDTH+1:WIDTH] != 0".
   function automatic logic acc_ovf(
      input logic [MAX_W-1:0] acc,
      input logic [MAX_W-1:0] a,
      input logic [MAX_W-1:0] b,
      input int               width
   );
      return acc_raw(acc, a, b) > acc_limit(width);
   endfunction

   // New accumulator value: clamp to all-ones when saturating, else keep the
   // low WIDTH bits. The caller truncates the result to WIDTH bits.
   function automatic logic [EXT_W-1:0] acc_sum(
      input logic [MAX_W-1:0] acc,
      input logic [MAX_W-1:0] a,
      input logic [MAX_W-1:0] b,
      input int               width,
      input bit               sat
   );
      logic [EXT_W-1:0] raw;
      logic [EXT_W-1:0] lim;
      raw = acc_raw(acc, a, b);
      lim = acc_limit(width);
      if (sat && (raw > lim)) begin
         return lim;
      end
      return raw & lim;
   endfunction

endpackage

// File: rtl/add_acc_datapath.sv
// Accumulator, beat counter and sticky overflow registers of add_acc_unit,
// plus the wrap/saturate selection for the next accumulator value.
// Build option: define ADD_ACC_SAT_EN for saturating accumulation; the
// default build wraps modulo 2^WIDTH. Overflow is reported in both modes.
// The *_nxt outputs are the values these registers take if the current beat
// is accepted; the top captures them into its result registers on the
// closing beat.
module add_acc_datapath
   import add_acc_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic [WIDTH-1:0] acc_nxt,
   output logic [CNT_W-1:0] cnt_nxt,
   output logic             ovf_nxt
);

`ifdef ADD_ACC_SAT_EN
   localparam bit SAT_EN = 1'b1;
`else
   localparam bit SAT_EN = 1'b0;
`endif

   logic [WIDTH-1:0] acc;
   logic [CNT_W-1:0] count;
   logic             ovf;

   // Next-state arithmetic for an accepted beat.
   always_comb begin
      // NOTE: every output of a combinational block is assigned on every
      // pass; a path that skips one would infer a latch.
      acc_nxt = WIDTH'(acc_sum(MAX_W'(acc), MAX_W'(in_a), MAX_W'(in_b),
                               WIDTH, SAT_EN));
      ovf_nxt = ovf | acc_ovf(MAX_W'(acc), MAX_W'(in_a), MAX_W'(in_b), WIDTH);
      cnt_nxt = count + CNT_W'(1);
   end

   // Batch state: cleared by reset or when the result is taken, advanced on
   // each accepted beat, otherwise held.
   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (rst || clr) begin
         acc   <= '0;
         count <= '0;
         ovf   <= 1'b0;
      end else if (en) begin
         acc   <= acc_nxt;
         count <= cnt_nxt;
         ovf   <= ovf_nxt;
      end
   end

endmodule

// File: rtl/add_acc_unit.sv
// Add-accumulate unit: sums a+b of each accepted operand pair into a running
// total and presents one registered result after BATCH pairs or on an
// in_last beat. Holds the control FSM, both handshakes and the result
// registers; arithmetic lives in add_acc_datapath.
// Build option: ADD_ACC_SAT_EN selects saturating instead of wrapping
// accumulation (see add_acc_datapath).
module add_acc_unit
   import add_acc_pkg::*;
#(
   parameter  int WIDTH = 8,
   parameter  int BATCH = 4,
   localparam int CNT_W = $clog2(BATCH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic [CNT_W-1:0] out_count,
   output logic             out_ovf
);

   if (WIDTH < 2 || WIDTH > int'(MAX_W)) begin : g_bad_width
      $error("add_acc_unit: WIDTH out of supported range");
   end
   if (BATCH < 1) begin : g_bad_batch
      $error("add_acc_unit: BATCH must be at least 1");
   end

   acc_state_t       state;
   logic             accept;
   logic             closing;
   logic             release_res;
   logic [WIDTH-1:0] acc_nxt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             ovf_nxt;

   // Ready depends only on the state register and reset, never on in_* or
   // out_ready, so neither handshake has a combinational loop through here.
   assign in_ready    = !rst && (state != HOLD);
   assign accept      = in_valid && in_ready;
   assign closing     = accept && (in_last || (cnt_nxt == CNT_W'(BATCH)));
   assign release_res = (state == HOLD) && out_ready;

   add_acc_datapath #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_datapath (
      .clk     (clk),
      .rst     (rst),
      .clr     (release_res),
      .en      (accept),
      .in_a    (in_a),
      .in_b    (in_b),
      .acc_nxt (acc_nxt),
      .cnt_nxt (cnt_nxt),
      .ovf_nxt (ovf_nxt)
   );

   // Control FSM with registered result outputs. The result registers load
   // only on the closing beat, so they stay stable through HOLD and keep
   // their last value after the handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         out_valid <= 1'b0;
         out_sum   <= '0;
         out_count <= '0;
         out_ovf   <= 1'b0;
      end else begin
         case (state)
            IDLE, ACCUM: begin
               if (accept) begin
                  if (closing) begin
                     state     <= HOLD;
                     out_valid <= 1'b1;
                     out_sum   <= acc_nxt;
                     out_count <= cnt_nxt;
                     out_ovf   <= ovf_nxt;
                  end else begin
                     state <= ACCUM;
                  end
               end
            end
            HOLD: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
               end
            end
            default: begin
               state     <= IDLE;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_add_acc_unit.sv
// Directed self-checking bench for add_acc_unit at WIDTH=8, BATCH=4.
// Expected values are hand-computed; the overflow case selects its expected
// sum by the ADD_ACC_SAT_EN build option.
module tb_add_acc_unit;

   localparam int WIDTH = 8;
   localparam int BATCH = 4;
   localparam int CNT_W = 3;

`ifdef ADD_ACC_SAT_EN
   localparam int OVF_SUM = 255;
`else
   localparam int OVF_SUM = 4;
`endif

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_sum;
   logic [CNT_W-1:0] out_count;
   logic             out_ovf;

   int checks   = 0;
   int failures = 0;

   add_acc_unit #(
      .WIDTH (WIDTH),
      .BATCH (BATCH)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_count (out_count),
      .out_ovf   (out_ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] observed,
                        input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1 ns after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Offer one pair, confirm it will be taken, and clock it in.
   task automatic send(input string tag, input int a, input int b,
                       input logic last);
      in_valid = 1'b1;
      in_a     = WIDTH'(a);
      in_b     = WIDTH'(b);
      in_last  = last;
      check({tag, "_ready"}, 32'(in_ready), 32'd1);
      step();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic check_result(input string tag, input int sum, input int cnt,
                               input logic ovf);
      check({tag, "_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_sum"},   32'(out_sum),   32'(sum));
      check({tag, "_count"}, 32'(out_count), 32'(cnt));
      check({tag, "_ovf"},   32'(out_ovf),   32'(ovf));
      check({tag, "_busy"},  32'(in_ready),  32'd0);
   endtask

   // Take the presented result and confirm the unit is ready again.
   task automatic release_result(input string tag);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check({tag, "_rel_valid"}, 32'(out_valid), 32'd0);
      check({tag, "_rel_ready"}, 32'(in_ready),  32'd1);
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      in_last   = 1'b0;
      out_ready = 1'b0;
      #1;
      step();
      step();

      // Reset state
      check("rst_ready", 32'(in_ready),  32'd0);
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_sum",   32'(out_sum),   32'd0);
      check("rst_count", 32'(out_count), 32'd0);
      check("rst_ovf",   32'(out_ovf),   32'd0);
      rst = 1'b0;
      #1;
      check("post_rst_ready", 32'(in_ready), 32'd1);

      // Back-to-back full batch: 60+72+35+50 = 217
      send("b2b0", 10, 50, 1'b0);
      check("b2b0_nvalid", 32'(out_valid), 32'd0);
      send("b2b1", 12, 60, 1'b0);
      send("b2b2", 15, 20, 1'b0);
      send("b2b3", 20, 30, 1'b0);
      check_result("b2b", 217, 4, 1'b0);
      step();
      check_result("b2b_wait", 217, 4, 1'b0);
      release_result("b2b");
      check("b2b_keep_sum", 32'(out_sum), 32'd217);

      // Overflow: 250, then 260 -> wraps to 4 or saturates to 255
      send("ovf0", 200, 50, 1'b0);
      send("ovf1", 10, 0, 1'b1);
      check_result("ovf", OVF_SUM, 2, 1'b1);
      release_result("ovf");

      // Early close on the first beat; ovf must have cleared
      send("early", 15, 70, 1'b1);
      check_result("early", 85, 1, 1'b0);

      // Backpressure: in_valid offered during HOLD must be ignored
      in_valid = 1'b1;
      in_a     = 8'd1;
      in_b     = 8'd1;
      for (int i = 0; i < 5; i++) begin
         step();
         check_result("bp", 85, 1, 1'b0);
      end
      in_valid = 1'b0;
      release_result("bp");
      send("bp_next", 1, 1, 1'b1);
      check_result("bp_next", 2, 1, 1'b0);
      release_result("bp_next");

      // Reset mid-batch discards the partial sum
      send("mid0", 1, 1, 1'b0);
      send("mid1", 1, 1, 1'b0);
      rst = 1'b1;
      #1;
      check("mid_rst_ready", 32'(in_ready), 32'd0);
      step();
      check("mid_rst_valid", 32'(out_valid), 32'd0);
      check("mid_rst_sum",   32'(out_sum),   32'd0);
      check("mid_rst_count", 32'(out_count), 32'd0);
      check("mid_rst_ovf",   32'(out_ovf),   32'd0);
      rst = 1'b0;
      #1;
      for (int i = 0; i < 4; i++) begin
         send("after_rst", 1, 1, 1'b0);
      end
      check_result("after_rst", 8, 4, 1'b0);
      release_result("after_rst");

      // Gapped version of the 217 batch
      send("gap0", 10, 50, 1'b0);
      repeat (3) step();
      check("gap_idle_valid", 32'(out_valid), 32'd0);
      send("gap1", 12, 60, 1'b0);
      repeat (3) step();
      send("gap2", 15, 20, 1'b0);
      repeat (3) step();
      check("gap_idle_ready", 32'(in_ready), 32'd1);
      send("gap3", 20, 30, 1'b0);
      check_result("gap", 217, 4, 1'b0);
      release_result("gap");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
